sim_run_ctrl: RTL and testbench

//   Parametrised run controller for CPU bring-up: sequences the core's reset, counts cycles and
//   GRF commits, folds writes into a signature, and ends a run on halt-PC or timeout.

---
 rtl/sim_run_ctrl.sv | 109 ++++++++++
 tb/tb_sim_run_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sim_run_ctrl.sv
// Run controller for CPU bring-up: sequences core reset, counts RUN cycles and GRF
// commits, folds commits into a rolling signature, and stops on halt PC or timeout.
module sim_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 100000,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PC_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  halt_pc,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  input  logic             grf_we,
  input  logic [4:0]       grf_addr,
  input  logic [31:0]      grf_wdata,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] commit_cnt,
  output logic [31:0]      signature
);

  localparam int unsigned RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0]    RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [RW-1:0]    rcnt, rcnt_n;
  logic [CNT_W-1:0] cyc_n, com_n;
  logic [31:0]      sig_n;
  logic             to_n;
  logic             commit, halt;

  assign commit = grf_we && (grf_addr != 5'd0);
  assign halt   = pc_valid && (pc == halt_pc);

  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    cyc_n   = cycle_cnt;
    com_n   = commit_cnt;
    sig_n   = signature;
    to_n    = timeout;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RST;
          rcnt_n  = RST_LAST;
          cyc_n   = '0;
          com_n   = '0;
          sig_n   = '0;
          to_n    = 1'b0;
        end
      end
      RST: begin
        if (rcnt == '0) state_n = RUN;
        else            rcnt_n  = rcnt - 1'b1;
      end
      RUN: begin
        if (cycle_cnt != '1) cyc_n = cycle_cnt + 1'b1;
        if (commit) begin
          if (commit_cnt != '1) com_n = commit_cnt + 1'b1;
          sig_n = {signature[30:0], signature[31]} ^ grf_wdata ^ {27'b0, grf_addr};
        end
        // Halt takes priority over a coincident timeout.
        if (halt) begin
          state_n = DONE;
          to_n    = 1'b0;
        end else if (cycle_cnt == TO_LAST) begin
          state_n = DONE;
          to_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rcnt       <= '0;
      cycle_cnt  <= '0;
      commit_cnt <= '0;
      signature  <= '0;
      timeout    <= 1'b0;
      cpu_reset  <= 1'b1;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      rcnt       <= rcnt_n;
      cycle_cnt  <= cyc_n;
      commit_cnt <= com_n;
      signature  <= sig_n;
      timeout    <= to_n;
      cpu_reset  <= (state_n != RUN);
      running    <= (state_n == RUN);
      done       <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: reset/idle, RST length, commits and signature,
// halt, timeout, halt-vs-timeout, reset mid-run and ignored starts.
module tb_sim_run_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, pc_valid, grf_we;
  logic [31:0] halt_pc, pc, grf_wdata;
  logic [4:0]  grf_addr;
  logic        cpu_reset, running, done, timeout;
  logic [31:0] cycle_cnt, commit_cnt, signature;

  int checks = 0;
  int errors = 0;

  sim_run_ctrl #(
    .RESET_CYCLES(4),
    .TIMEOUT(50),
    .CNT_W(32),
    .PC_W(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt_pc(halt_pc), .pc(pc),
    .pc_valid(pc_valid), .grf_we(grf_we), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
    .cpu_reset(cpu_reset), .running(running), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .commit_cnt(commit_cnt), .signature(signature)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic cr, input logic rn,
                            input logic dn, input logic to);
    chk({tag, ".cpu_reset"}, {31'b0, cpu_reset}, {31'b0, cr});
    chk({tag, ".running"},   {31'b0, running},   {31'b0, rn});
    chk({tag, ".done"},      {31'b0, done},      {31'b0, dn});
    chk({tag, ".timeout"},   {31'b0, timeout},   {31'b0, to});
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] cy, input logic [31:0] cm,
                         input logic [31:0] sg);
    chk({tag, ".cycle_cnt"},  cycle_cnt,  cy);
    chk({tag, ".commit_cnt"}, commit_cnt, cm);
    chk({tag, ".signature"},  signature,  sg);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    grf_we = 1'b1; grf_addr = a; grf_wdata = d;
    step(1);
    grf_we = 1'b0; grf_addr = '0; grf_wdata = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pc_valid = 1'b0; grf_we = 1'b0;
    halt_pc = 32'h3010; pc = '0; grf_addr = '0; grf_wdata = '0;

    // Reset and idle
    step(2);
    chk_status("rst", 1, 0, 0, 0);
    chk_cnt("rst", 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk_status("idle", 1, 0, 0, 0);
      chk("idle.cycle_cnt", cycle_cnt, 0);
    end

    // RST lasts exactly 4 cycles after the start edge
    pulse_start();
    chk_status("rst0", 1, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      step(1);
      chk_status("rstn", 1, 0, 0, 0);
    end
    step(1);
    chk_status("run0", 0, 1, 0, 0);
    chk_cnt("run0", 0, 0, 0);

    // Commits: $0 write is ignored; 0^5^1=4, rot(4)^3^2=9
    wr(5'd1, 32'h5);
    chk_cnt("wr1", 1, 1, 32'h4);
    wr(5'd0, 32'hFF);
    chk_cnt("wr0", 2, 1, 32'h4);
    wr(5'd2, 32'h3);
    chk_cnt("wr2", 3, 2, 32'h9);

    // start in RUN ignored
    pulse_start();
    chk_status("runstart", 0, 1, 0, 0);
    chk("runstart.cycle_cnt", cycle_cnt, 4);

    // pc matches but pc_valid low: no halt
    pc = 32'h3010;
    step(15);
    chk_status("nohalt", 0, 1, 0, 0);
    chk("nohalt.cycle_cnt", cycle_cnt, 19);

    // Halt on RUN cycle 20 with a commit folded in: rot(9)=0x12 ^0x10 ^3 = 0x01
    pc_valid = 1'b1; grf_we = 1'b1; grf_addr = 5'd3; grf_wdata = 32'h10;
    step(1);
    chk_status("halt", 1, 0, 1, 0);
    chk_cnt("halt", 20, 3, 32'h1);
    step(3);
    chk_status("frozen", 1, 0, 1, 0);
    chk_cnt("frozen", 20, 3, 32'h1);
    pc_valid = 1'b0; grf_we = 1'b0; grf_addr = '0; grf_wdata = '0; pc = '0;

    // Timeout run
    pulse_start();
    chk_status("to.rst", 1, 0, 0, 0);
    chk_cnt("to.rst", 0, 0, 0);
    step(4);
    chk_status("to.run", 0, 1, 0, 0);
    step(49);
    chk_status("to.49", 0, 1, 0, 0);
    chk("to.49.cycle_cnt", cycle_cnt, 49);
    step(1);
    chk_status("to.end", 1, 0, 1, 1);
    chk("to.end.cycle_cnt", cycle_cnt, 50);
    step(2);
    chk("to.hold.cycle_cnt", cycle_cnt, 50);
    chk_status("to.hold", 1, 0, 1, 1);

    // Halt coincides with timeout: halt wins
    pulse_start();
    chk_status("ht.rst", 1, 0, 0, 0);
    step(4);
    step(49);
    chk("ht.49.cycle_cnt", cycle_cnt, 49);
    pc = 32'h3010; pc_valid = 1'b1;
    step(1);
    chk_status("ht.end", 1, 0, 1, 0);
    chk("ht.end.cycle_cnt", cycle_cnt, 50);
    pc_valid = 1'b0; pc = '0;

    // Reset mid-run
    pulse_start();
    step(4);
    chk_status("mr.run", 0, 1, 0, 0);
    wr(5'd4, 32'h7);
    chk_cnt("mr.wr", 1, 1, 32'h3);
    step(9);
    chk("mr.cycle_cnt", cycle_cnt, 10);
    reset = 1'b1; start = 1'b1;
    step(1);
    reset = 1'b0; start = 1'b0;
    chk_status("mr.rst", 1, 0, 0, 0);
    chk_cnt("mr.rst", 0, 0, 0);
    step(6);
    chk_status("mr.idle", 1, 0, 0, 0);

    // Full RST sequence repeats
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_status("mr.rstn", 1, 0, 0, 0);
    end
    step(1);
    chk_status("mr.run2", 0, 1, 0, 0);
    chk_cnt("mr.run2", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
